// File: rtl/ps2_keyb_pkg.sv
// Shared definitions for the PS/2 keyboard front end.
//   - rx_state_t : receiver FSM encoding
//   - pos_t      : one key matrix position {row, col}
//   - key_map_t  : lookup result, up to two positions plus a count
//   - key_lookup : (ext, set-2 code) -> matrix positions
package ps2_keyb_pkg;

  localparam int NUM_ROWS = 8;
  localparam int NUM_COLS = 5;

  localparam logic [7:0] CODE_BRK = 8'hF0;
  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_PAU = 8'hE1;
  localparam logic [7:0] CODE_BAT = 8'hAA;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
  } pos_t;

  typedef struct packed {
    logic [1:0] cnt;
    pos_t       p0;
    pos_t       p1;
  } key_map_t;

  function automatic key_map_t one(input int r, input int c);
    key_map_t m;
    m.cnt = 2'd1;
    m.p0  = '{row: 3'(r), col: 3'(c)};
    m.p1  = '0;
    return m;
  endfunction

  // Second position always pairs with Caps Shift (row 0, col 0).
  function automatic key_map_t with_cs(input int r, input int c);
    key_map_t m;
    m.cnt = 2'd2;
    m.p0  = '0;
    m.p1  = '{row: 3'(r), col: 3'(c)};
    return m;
  endfunction

  function automatic key_map_t key_lookup(input logic ext, input logic [7:0] code);
    key_map_t m;
    m = '0;
    if (ext) begin
      case (code)
        8'h6B: m = with_cs(3, 4);  // left  -> CS+5
        8'h72: m = with_cs(4, 4);  // down  -> CS+6
        8'h75: m = with_cs(4, 3);  // up    -> CS+7
        8'h74: m = with_cs(4, 2);  // right -> CS+8
        default: m = '0;
      endcase
    end else begin
      case (code)
        8'h12, 8'h59: m = one(0, 0);  // shifts -> CS
        8'h1A: m = one(0, 1);  8'h22: m = one(0, 2);
        8'h21: m = one(0, 3);  8'h2A: m = one(0, 4);
        8'h1C: m = one(1, 0);  8'h1B: m = one(1, 1);
        8'h23: m = one(1, 2);  8'h2B: m = one(1, 3);
        8'h34: m = one(1, 4);
        8'h15: m = one(2, 0);  8'h1D: m = one(2, 1);
        8'h24: m = one(2, 2);  8'h2D: m = one(2, 3);
        8'h2C: m = one(2, 4);
        8'h16: m = one(3, 0);  8'h1E: m = one(3, 1);
        8'h26: m = one(3, 2);  8'h25: m = one(3, 3);
        8'h2E: m = one(3, 4);
        8'h45: m = one(4, 0);  8'h46: m = one(4, 1);
        8'h3E: m = one(4, 2);  8'h3D: m = one(4, 3);
        8'h36: m = one(4, 4);
        8'h4D: m = one(5, 0);  8'h44: m = one(5, 1);
        8'h43: m = one(5, 2);  8'h3C: m = one(5, 3);
        8'h35: m = one(5, 4);
        8'h5A: m = one(6, 0);  8'h4B: m = one(6, 1);
        8'h42: m = one(6, 2);  8'h3B: m = one(6, 3);
        8'h33: m = one(6, 4);
        8'h29: m = one(7, 0);  8'h14: m = one(7, 1);  // space, ctrl -> SS
        8'h3A: m = one(7, 2);  8'h31: m = one(7, 3);
        8'h32: m = one(7, 4);
        8'h66: m = with_cs(4, 0);  // backspace -> CS+0
        default: m = '0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronisers, ps2clk glitch filter, frame FSM and
// partial-frame timeout.
//   clk, rst_n        : system clock, async active-low reset
//   ps2clk, ps2data   : raw asynchronous PS/2 lines
//   scancode          : last good byte
//   scancode_valid    : 1-cycle pulse when scancode loads
//   rx_err            : 1-cycle pulse on parity or stop-bit error
module ps2_rx
  import ps2_keyb_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 28000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic [7:0] scancode,
  output logic       scancode_valid,
  output logic       rx_err
);

  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  logic [1:0]       clk_s;
  logic [1:0]       dat_s;
  logic [FLT_W-1:0] flt_cnt;
  logic             flt_lvl;
  logic             flt_flip;
  logic             fall;

  rx_state_t        state;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             par_ok;
  logic [TO_W-1:0]  to_cnt;

  // Filtered level flips only after FILTER_LEN consecutive differing samples.
  assign flt_flip = (clk_s[1] != flt_lvl) && (flt_cnt == FLT_W'(FILTER_LEN - 1));
  assign fall     = flt_flip && flt_lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s   <= 2'b11;
      dat_s   <= 2'b11;
      flt_cnt <= '0;
      flt_lvl <= 1'b1;
    end else begin
      clk_s <= {clk_s[0], ps2clk};
      dat_s <= {dat_s[0], ps2data};
      if (clk_s[1] == flt_lvl) begin
        flt_cnt <= '0;
      end else if (flt_flip) begin
        flt_cnt <= '0;
        flt_lvl <= clk_s[1];
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RX_IDLE;
      bit_cnt        <= '0;
      shreg          <= '0;
      par_ok         <= 1'b0;
      to_cnt         <= '0;
      scancode       <= '0;
      scancode_valid <= 1'b0;
      rx_err         <= 1'b0;
    end else begin
      scancode_valid <= 1'b0;
      rx_err         <= 1'b0;
      if (fall) begin
        // An edge always restarts the timeout, so it wins a same-cycle expiry.
        to_cnt <= '0;
        case (state)
          RX_IDLE: begin
            if (!dat_s[1]) begin
              state   <= RX_DATA;
              bit_cnt <= '0;
            end
          end
          RX_DATA: begin
            shreg   <= {dat_s[1], shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= RX_PARITY;
          end
          RX_PARITY: begin
            // Odd parity: data plus parity bit hold an odd number of ones.
            par_ok <= (^shreg) ^ dat_s[1];
            state  <= RX_STOP;
          end
          RX_STOP: begin
            if (dat_s[1] && par_ok) begin
              scancode       <= shreg;
              scancode_valid <= 1'b1;
            end else begin
              rx_err <= 1'b1;
            end
            state <= RX_IDLE;
          end
          default: state <= RX_IDLE;
        endcase
      end else if (state != RX_IDLE) begin
        if (to_cnt == TO_W'(TIMEOUT - 1)) begin
          state  <= RX_IDLE;
          to_cnt <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_keyb_matrix.sv
// PS/2 keyboard to ZX Spectrum 8x5 key matrix.
//   clk, rst_n      : system clock, async active-low reset
//   ps2clk, ps2data : raw PS/2 lines
//   rows            : active-low row selects (CPU A15..A8)
//   cols            : active-low column readback, combinational from rows
//   scancode, scancode_valid, rx_err : receiver status
module ps2_keyb_matrix
  import ps2_keyb_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 28000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2clk,
  input  logic       ps2data,
  input  logic [7:0] rows,
  output logic [4:0] cols,
  output logic [7:0] scancode,
  output logic       scancode_valid,
  output logic       rx_err
);

  logic [NUM_ROWS-1:0][NUM_COLS-1:0] matrix;  // 0 = pressed
  logic       ext;
  logic       brk;
  logic [2:0] skip;
  key_map_t   hit;

  ps2_rx #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT   (TIMEOUT)
  ) u_rx (
    .clk           (clk),
    .rst_n         (rst_n),
    .ps2clk        (ps2clk),
    .ps2data       (ps2data),
    .scancode      (scancode),
    .scancode_valid(scancode_valid),
    .rx_err        (rx_err)
  );

  assign hit = key_lookup(ext, scancode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      matrix <= '1;
      ext    <= 1'b0;
      brk    <= 1'b0;
      skip   <= '0;
    end else if (scancode_valid) begin
      if (skip != 3'd0) begin
        skip <= skip - 1'b1;  // swallowing the Pause sequence
      end else if (scancode == CODE_BRK) begin
        brk <= 1'b1;
      end else if (scancode == CODE_EXT) begin
        ext <= 1'b1;
      end else if (scancode == CODE_PAU) begin
        skip <= 3'd7;
      end else if (scancode == CODE_BAT && !brk) begin
        matrix <= '1;
        ext    <= 1'b0;
      end else begin
        // Positions shared by two keys are not counted: last event wins.
        if (hit.cnt != 2'd0) matrix[hit.p0.row][hit.p0.col] <= brk;
        if (hit.cnt == 2'd2) matrix[hit.p1.row][hit.p1.col] <= brk;
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end

  always_comb begin
    cols = '1;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (!rows[r]) cols = cols & matrix[r];
    end
  end

endmodule

// File: tb/tb_ps2_keyb_matrix.sv
module tb_ps2_keyb_matrix;

  logic       clk;
  logic       rst_n;
  logic       ps2clk;
  logic       ps2data;
  logic [7:0] rows;
  logic [4:0] cols;
  logic [7:0] scancode;
  logic       scancode_valid;
  logic       rx_err;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_valid = 0;
  int n_err   = 0;

  ps2_keyb_matrix dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ps2clk        (ps2clk),
    .ps2data       (ps2data),
    .rows          (rows),
    .cols          (cols),
    .scancode      (scancode),
    .scancode_valid(scancode_valid),
    .rx_err        (rx_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (scancode_valid === 1'b1) n_valid++;
    if (rx_err === 1'b1) n_err++;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2data = b;
    wait_clks(10);
    ps2clk = 1'b0;
    wait_clks(20);
    ps2clk = 1'b1;
    wait_clks(10);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par_inv);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    send_bit((~^data) ^ par_inv);
    send_bit(1'b1);
    ps2data = 1'b1;
    wait_clks(20);
  endtask

  task automatic set_rows(input logic [7:0] r);
    @(negedge clk);
    rows = r;
    #1;
  endtask

  task automatic clear_counts();
    @(negedge clk);
    #1;
    n_valid = 0;
    n_err   = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    ps2clk = 1'b1;
    ps2data = 1'b1;
    rows = 8'h00;
    wait_clks(5);
    @(negedge clk);
    n_cmp++; if (cols !== 5'b11111) begin n_fail++; $display("FAIL reset_cols got=%b exp=11111", cols); end
    n_cmp++; if (scancode !== 8'h00) begin n_fail++; $display("FAIL reset_scancode got=%h exp=00", scancode); end
    rst_n = 1'b1;
    wait_clks(10);
    @(negedge clk);
    n_cmp++; if (cols !== 5'b11111) begin n_fail++; $display("FAIL post_reset_cols got=%b exp=11111", cols); end
    n_cmp++; if (n_valid !== 0 || n_err !== 0) begin n_fail++; $display("FAIL reset_pulses got valid=%0d err=%0d exp 0/0", n_valid, n_err); end
  endtask

  task automatic test_key_a();
    clear_counts();
    send_frame(8'h1C, 1'b0);
    n_cmp++; if (n_valid !== 1) begin n_fail++; $display("FAIL key_a_valid_count got=%0d exp=1", n_valid); end
    n_cmp++; if (scancode !== 8'h1C) begin n_fail++; $display("FAIL key_a_scancode got=%h exp=1c", scancode); end
    set_rows(8'hFD);
    n_cmp++; if (cols !== 5'b11110) begin n_fail++; $display("FAIL key_a_row1 got=%b exp=11110", cols); end
    set_rows(8'hFE);
    n_cmp++; if (cols !== 5'b11111) begin n_fail++; $display("FAIL key_a_row0 got=%b exp=11111", cols); end
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    set_rows(8'hFD);
    n_cmp++; if (cols !== 5'b11111) begin n_fail++; $display("FAIL key_a_release got=%b exp=11111", cols); end
  endtask

  task automatic test_parity_error();
    clear_counts();
    send_frame(8'h1C, 1'b1);
    n_cmp++; if (n_err !== 1) begin n_fail++; $display("FAIL parity_err_count got=%0d exp=1", n_err); end
    n_cmp++; if (n_valid !== 0) begin n_fail++; $display("FAIL parity_valid_count got=%0d exp=0", n_valid); end
    set_rows(8'hFD);
    n_cmp++; if (cols !== 5'b11111) begin n_fail++; $display("FAIL parity_cols got=%b exp=11111", cols); end
  endtask

  task automatic test_cursor_up();
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    set_rows(8'hFE);
    n_cmp++; if (cols !== 5'b11110) begin n_fail++; $display("FAIL up_row0 got=%b exp=11110", cols); end
    set_rows(8'hEF);
    n_cmp++; if (cols !== 5'b10111) begin n_fail++; $display("FAIL up_row4 got=%b exp=10111", cols); end
    set_rows(8'hEE);
    n_cmp++; if (cols !== 5'b10110) begin n_fail++; $display("FAIL up_row04 got=%b exp=10110", cols); end
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    set_rows(8'h00);
    n_cmp++; if (cols !== 5'b11111) begin n_fail++; $display("FAIL up_release got=%b exp=11111", cols); end
  endtask

  task automatic test_timeout();
    clear_counts();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    ps2data = 1'b1;
    wait_clks(33600);  // 1.2 ms at 28 MHz
    send_frame(8'h29, 1'b0);
    n_cmp++; if (n_valid !== 1) begin n_fail++; $display("FAIL timeout_valid_count got=%0d exp=1", n_valid); end
    n_cmp++; if (n_err !== 0) begin n_fail++; $display("FAIL timeout_err_count got=%0d exp=0", n_err); end
    n_cmp++; if (scancode !== 8'h29) begin n_fail++; $display("FAIL timeout_scancode got=%h exp=29", scancode); end
    set_rows(8'h7F);
    n_cmp++; if (cols !== 5'b11110) begin n_fail++; $display("FAIL timeout_space got=%b exp=11110", cols); end
    send_frame(8'hF0, 1'b0);
    send_frame(8'h29, 1'b0);
  endtask

  task automatic test_multi_row_reset();
    send_frame(8'h1C, 1'b0);
    send_frame(8'h15, 1'b0);
    set_rows(8'h00);
    n_cmp++; if (cols !== 5'b11110) begin n_fail++; $display("FAIL multi_aq got=%b exp=11110", cols); end
    set_rows(8'hFB);
    n_cmp++; if (cols !== 5'b11110) begin n_fail++; $display("FAIL multi_q_row2 got=%b exp=11110", cols); end
    // Partial frame, then a one-cycle reset with the PS/2 clock high.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    ps2data = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_rows(8'h00);
    n_cmp++; if (cols !== 5'b11111) begin n_fail++; $display("FAIL midreset_cols got=%b exp=11111", cols); end
    clear_counts();
    send_frame(8'h1C, 1'b0);
    n_cmp++; if (n_valid !== 1 || n_err !== 0) begin n_fail++; $display("FAIL midreset_pulses got valid=%0d err=%0d exp 1/0", n_valid, n_err); end
    n_cmp++; if (scancode !== 8'h1C) begin n_fail++; $display("FAIL midreset_scancode got=%h exp=1c", scancode); end
    set_rows(8'hFD);
    n_cmp++; if (cols !== 5'b11110) begin n_fail++; $display("FAIL midreset_key_a got=%b exp=11110", cols); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_key_a();
    test_parity_error();
    test_cursor_up();
    test_timeout();
    test_multi_row_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
